// File: rtl/count_down_timer.sv
// Loadable down-counting timer with one-shot/auto-reload expiry and pause/resume.
// Latency: y, busy, paused and done are registered; load/start take effect at the next edge.
// Backpressure: load_ready drops while running; loads offered in RUN are not accepted.
module count_down_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             res,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_value,
  input  logic             auto_reload,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] y,
  output logic             busy,
  output logic             paused,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] y_q, y_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             done_q, done_d;

  logic             load_fire;
  logic [WIDTH-1:0] y_eff;

  // Handshake: a load is accepted whenever the timer is not counting.
  always_comb begin
    load_ready = (state_q != RUN);
    load_fire  = load_valid && load_ready;
    y_eff      = load_fire ? load_value : y_q;
  end

  // Next-state and datapath: loads, start/stop arbitration, decrement and expiry.
  always_comb begin
    state_d  = state_q;
    y_d      = y_q;
    reload_d = reload_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE, PAUSE: begin
        if (load_fire) begin
          y_d      = load_value;
          reload_d = load_value;
        end
        // stop only blocks a start when paused; in IDLE stop has no meaning.
        if (start && (y_eff != '0) && !(state_q == PAUSE && stop)) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          // Pause wins over expiry, so y may legitimately hold at 1.
          state_d = PAUSE;
        end else if (y_q > WIDTH'(1)) begin
          y_d = y_q - WIDTH'(1);
        end else if (y_q == WIDTH'(1)) begin
          done_d = 1'b1;
          if (auto_reload) begin
            y_d = reload_q;
          end else begin
            y_d     = '0;
            state_d = IDLE;
          end
        end else begin
          // y==0 cannot be held in RUN; recover to IDLE without wrapping.
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q  <= IDLE;
      y_q      <= '0;
      reload_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      y_q      <= y_d;
      reload_q <= reload_d;
      done_q   <= done_d;
    end
  end

  // Status outputs follow the registered state directly.
  always_comb begin
    y      = y_q;
    busy   = (state_q == RUN);
    paused = (state_q == PAUSE);
    done   = done_q;
  end

endmodule
